// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, looked up in IF and trained from ID.
// Optional macro BP_BYPASS_EN forwards a same-cycle training write into the lookup.
module branch_predictor #(
  parameter int          IDX_W    = 4,
  parameter logic [1:0]  CTR_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic [31:0] pred_npc,
  input  logic        stall,
  input  logic        flush,
  output logic        id_choice,
  output logic [31:0] id_chosen_addr,
  output logic [31:0] id_pc,
  input  logic        upd_en,
  input  logic        upd_br,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [31:0] upd_pc
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH-1:0][1:0]  ctr_q;
  logic [TAG_W-1:0]       tag_q    [DEPTH];
  logic [31:0]            target_q [DEPTH];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_act, u_hit, wr_en;

  logic             new_valid;
  logic [TAG_W-1:0] new_tag;
  logic [31:0]      new_target;
  logic [1:0]       new_ctr;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_target;
  logic [1:0]       rd_ctr;
  logic             taken;
  logic [31:0]      seq_npc;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  assign l_idx = if_pc[IDX_W+1:2];
  assign l_tag = if_pc[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign u_act = upd_en & upd_br;
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Post-update image of the entry at u_idx; equals the stored entry when nothing is written.
  always_comb begin
    new_valid  = valid_q[u_idx];
    new_tag    = tag_q[u_idx];
    new_target = target_q[u_idx];
    new_ctr    = ctr_q[u_idx];
    wr_en      = 1'b0;
    if (u_act) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          new_ctr    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
          new_target = upd_target;
        end else begin
          new_ctr    = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        wr_en      = 1'b1;
        new_valid  = 1'b1;
        new_tag    = u_tag;
        new_target = upd_target;
        new_ctr    = CTR_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ctr_q   <= {DEPTH{2'b01}};
    end else if (wr_en) begin
      valid_q[u_idx] <= new_valid;
      ctr_q[u_idx]   <= new_ctr;
    end
  end

  // NOTE: tag/target arrays are left unreset on purpose; valid gates every use, so
  // clearing them would only add reset fan-out to a RAM-like structure.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[u_idx]    <= new_tag;
      target_q[u_idx] <= new_target;
    end
  end

  always_comb begin
    rd_valid  = valid_q[l_idx];
    rd_tag    = tag_q[l_idx];
    rd_target = target_q[l_idx];
    rd_ctr    = ctr_q[l_idx];
`ifdef BP_BYPASS_EN
    if (u_act && (u_idx == l_idx) && (u_tag == l_tag)) begin
      rd_valid  = new_valid;
      rd_tag    = new_tag;
      rd_target = new_target;
      rd_ctr    = new_ctr;
    end
`endif
  end

  assign taken    = rd_valid && (rd_tag == l_tag) && rd_ctr[1];
  assign seq_npc  = if_pc + 32'd4;
  assign pred_npc = taken ? rd_target : seq_npc;

  // IF/ID prediction registers; flush wins over stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_choice      <= 1'b0;
      id_chosen_addr <= '0;
      id_pc          <= '0;
    end else if (flush) begin
      id_choice      <= 1'b0;
      id_chosen_addr <= '0;
      id_pc          <= '0;
    end else if (!stall) begin
      id_choice      <= taken;
      id_chosen_addr <= pred_npc;
      id_pc          <= if_pc;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor plus hand sequences for
// same-cycle update/lookup and asynchronous reset.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic [31:0] pred_npc;
  logic        stall, flush;
  logic        id_choice;
  logic [31:0] id_chosen_addr, id_pc;
  logic        upd_en, upd_br, upd_taken;
  logic [31:0] upd_target, upd_pc;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NEUTRAL = 32'h0000_0010;

  typedef struct {
    logic [31:0] if_pc;
    logic        upd_en, upd_br, upd_taken;
    logic [31:0] upd_pc, upd_target;
    logic        stall, flush;
    logic [31:0] exp_npc;
    logic        exp_choice;
    logic [31:0] exp_addr, exp_pc;
  } vec_t;

  vec_t vecs[$];

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_npc(pred_npc),
    .stall(stall), .flush(flush), .id_choice(id_choice),
    .id_chosen_addr(id_chosen_addr), .id_pc(id_pc),
    .upd_en(upd_en), .upd_br(upd_br), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pc(upd_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Plain fetch, no training.
  task automatic add_fetch(input logic [31:0] pc, input logic [31:0] npc, input logic ch);
    vecs.push_back('{pc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, npc, ch, npc, pc});
  endtask

  // Training on upd_pc while fetching an untouched index.
  task automatic add_upd(input logic en, input logic br, input logic tk,
                         input logic [31:0] up, input logic [31:0] tg);
    vecs.push_back('{NEUTRAL, en, br, tk, up, tg, 1'b0, 1'b0,
                     NEUTRAL + 32'd4, 1'b0, NEUTRAL + 32'd4, NEUTRAL});
  endtask

  // Stall/flush row: fetch neutral, expect given id_* afterwards.
  task automatic add_ctl(input logic st, input logic fl, input logic ch,
                         input logic [31:0] ad, input logic [31:0] pc);
    vecs.push_back('{NEUTRAL, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, st, fl,
                     NEUTRAL + 32'd4, ch, ad, pc});
  endtask

  task automatic idle_inputs();
    upd_en = 1'b0; upd_br = 1'b0; upd_taken = 1'b0;
    upd_pc = '0; upd_target = '0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    if_pc = 32'h0000_0040;
    idle_inputs();

    // Reset state
    #2;
    check("reset pred_npc", pred_npc, 32'h0000_0044);
    check("reset id_choice", {31'b0, id_choice}, 32'h0);
    check("reset id_chosen_addr", id_chosen_addr, 32'h0);
    check("reset id_pc", id_pc, 32'h0);
    #8;   // t=10, between edges
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    add_fetch(32'h0000_0040, 32'h0000_0044, 1'b0);
    add_upd(1, 1, 1, 32'h0000_0040, 32'h0000_0100);         // allocate, ctr=10
    add_fetch(32'h0000_0040, 32'h0000_0100, 1'b1);
    add_upd(1, 1, 0, 32'h0000_0040, 32'h0);                  // 01
    add_upd(1, 1, 0, 32'h0000_0040, 32'h0);                  // 00
    add_fetch(32'h0000_0040, 32'h0000_0044, 1'b0);
    add_upd(1, 1, 0, 32'h0000_0040, 32'h0);                  // 00 saturates
    add_upd(1, 1, 1, 32'h0000_0040, 32'h0000_0100);          // 01
    add_fetch(32'h0000_0040, 32'h0000_0044, 1'b0);
    add_upd(1, 1, 1, 32'h0000_0040, 32'h0000_0100);          // 10
    add_upd(1, 1, 1, 32'h0000_0040, 32'h0000_0100);          // 11
    add_upd(1, 1, 1, 32'h0000_0040, 32'h0000_0100);          // 11 saturates
    add_upd(1, 1, 0, 32'h0000_0040, 32'h0);                  // 10
    add_fetch(32'h0000_0040, 32'h0000_0100, 1'b1);
    add_upd(1, 1, 0, 32'h0000_0040, 32'h0);                  // 01
    add_fetch(32'h0000_0040, 32'h0000_0044, 1'b0);
    // Aliasing: 0x80 shares index 0 with 0x40
    add_upd(1, 1, 1, 32'h0000_0080, 32'h0000_0300);
    add_fetch(32'h0000_0040, 32'h0000_0044, 1'b0);
    add_fetch(32'h0000_0080, 32'h0000_0300, 1'b1);
    add_upd(1, 1, 0, 32'h0000_1040, 32'h0);                  // miss, not taken
    add_fetch(32'h0000_0080, 32'h0000_0300, 1'b1);
    // Gated updates change nothing
    add_upd(0, 1, 0, 32'h0000_0080, 32'h0);
    add_upd(0, 1, 0, 32'h0000_0080, 32'h0);
    add_upd(1, 0, 0, 32'h0000_0080, 32'h0);
    add_upd(1, 0, 0, 32'h0000_0080, 32'h0);
    add_fetch(32'h0000_0080, 32'h0000_0300, 1'b1);
    add_upd(0, 1, 1, 32'h0000_0020, 32'h0000_0500);
    add_fetch(32'h0000_0020, 32'h0000_0024, 1'b0);
    // Stall holds, flush beats stall
    add_fetch(32'h0000_0080, 32'h0000_0300, 1'b1);
    add_ctl(1, 0, 1'b1, 32'h0000_0300, 32'h0000_0080);
    add_ctl(1, 0, 1'b1, 32'h0000_0300, 32'h0000_0080);
    add_ctl(1, 1, 1'b0, 32'h0, 32'h0);
    add_ctl(0, 0, 1'b0, NEUTRAL + 32'd4, NEUTRAL);
    // PC wrap-around
    add_fetch(32'hFFFF_FFFC, 32'h0000_0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      if_pc      = vecs[i].if_pc;
      upd_en     = vecs[i].upd_en;
      upd_br     = vecs[i].upd_br;
      upd_taken  = vecs[i].upd_taken;
      upd_pc     = vecs[i].upd_pc;
      upd_target = vecs[i].upd_target;
      stall      = vecs[i].stall;
      flush      = vecs[i].flush;
      #1;
      check($sformatf("vec%0d pred_npc", i), pred_npc, vecs[i].exp_npc);
      @(posedge clk); #1;
      check($sformatf("vec%0d id_choice", i), {31'b0, id_choice}, {31'b0, vecs[i].exp_choice});
      check($sformatf("vec%0d id_chosen_addr", i), id_chosen_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d id_pc", i), id_pc, vecs[i].exp_pc);
    end

    // Same-cycle lookup and training on the same entry
    idle_inputs();
    if_pc = NEUTRAL;
    upd_en = 1'b1; upd_br = 1'b1; upd_taken = 1'b1;
    upd_pc = 32'h0000_0040; upd_target = 32'h0000_0100;     // re-allocate 0x40, ctr=10
    @(posedge clk); #1;
    if_pc = 32'h0000_0040;
    upd_target = 32'h0000_0200;                               // hit, ctr->11, target->0x200
    #1;
`ifdef BP_BYPASS_EN
    check("same-cycle pred_npc", pred_npc, 32'h0000_0200);
`else
    check("same-cycle pred_npc", pred_npc, 32'h0000_0100);
`endif
    @(posedge clk); #1;
    idle_inputs();
    check("same-cycle id_choice", {31'b0, id_choice}, 32'h1);
`ifdef BP_BYPASS_EN
    check("same-cycle id_chosen_addr", id_chosen_addr, 32'h0000_0200);
`else
    check("same-cycle id_chosen_addr", id_chosen_addr, 32'h0000_0100);
`endif
    #1;
    check("post-update pred_npc", pred_npc, 32'h0000_0200);

    // Asynchronous reset mid-cycle
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset pred_npc", pred_npc, 32'h0000_0044);
    check("async reset id_choice", {31'b0, id_choice}, 32'h0);
    check("async reset id_chosen_addr", id_chosen_addr, 32'h0);
    check("async reset id_pc", id_pc, 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after reset pred_npc", pred_npc, 32'h0000_0044);
    check("after reset id_pc", id_pc, 32'h0000_0040);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
